// File: rtl/irq_ctrl_multi.sv
// irq_ctrl_multi: N-source interrupt controller feeding the cv32e40p irq vector, with edge/level modes and a config port.
// Optional IRQ_LOSTCNT_EN builds per-source saturating lost-edge counters at config addresses 8+k.
module irq_ctrl_multi #(
    parameter int NUM_SRC     = 8,
    parameter int IRQ_BASE    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_BIT   = 7
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_irq,
    input  logic               i_irq_timer,
    output logic [31:0]        o_irq,
    input  logic               i_irq_ack,
    input  logic [4:0]         i_irq_id,
    input  logic               i_cfg_wren,
    input  logic               i_cfg_rden,
    input  logic [5:0]         i_cfg_addr,
    input  logic [31:0]        i_cfg_wdata,
    output logic               o_cfg_rvalid,
    output logic [31:0]        o_cfg_rdata
);
    localparam int N = NUM_SRC + 1;

    // The timer rides along as the top bit: enable forced on, mode forced edge.
    logic [N-1:0] raw, s, prev_q, pend_q, pend_d, ev, ack_hit, w1c, en_full, mode_full, hit;
    logic [NUM_SRC-1:0] en_q, en_d, mode_q, mode_d;
    logic [31:0] irq_q, irq_d, rdata_q, rdata_d, rd;
    logic rvalid_q, rvalid_d;
    logic unused_wdata;

    assign raw = {i_irq_timer, i_irq};
    assign unused_wdata = ^i_cfg_wdata;
    assign o_irq = irq_q;
    assign o_cfg_rdata = rdata_q;
    assign o_cfg_rvalid = rvalid_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = raw;
        end else begin : g_sync
            logic [N-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= raw;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        en_full   = {1'b1, en_q};
        mode_full = {1'b0, mode_q};
        ev        = s & (~prev_q | mode_full);
        for (int k = 0; k < N; k++)
            ack_hit[k] = i_irq_ack && (i_irq_id == 5'(k == NUM_SRC ? TIMER_BIT : IRQ_BASE + k));
        w1c    = {1'b0, (i_cfg_wren && i_cfg_addr == 6'd2) ? i_cfg_wdata[NUM_SRC-1:0] : {NUM_SRC{1'b0}}};
        pend_d = (pend_q & ~(ack_hit | w1c)) | ev;
        // An event landing with its own ack keeps the output up rather than blinking it.
        hit   = en_full & ((pend_q & ~ack_hit) | (ev & ack_hit));
        irq_d = '0;
        for (int k = 0; k < NUM_SRC; k++) irq_d[IRQ_BASE+k] = hit[k];
        irq_d[TIMER_BIT] = hit[NUM_SRC];
        en_d   = (i_cfg_wren && i_cfg_addr == 6'd0) ? i_cfg_wdata[NUM_SRC-1:0] : en_q;
        mode_d = (i_cfg_wren && i_cfg_addr == 6'd1) ? i_cfg_wdata[NUM_SRC-1:0] : mode_q;
    end

`ifdef IRQ_LOSTCNT_EN
    logic [7:0] cnt_q [NUM_SRC];
    logic [7:0] cnt_d [NUM_SRC];

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++)
            cnt_d[k] = (i_cfg_wren && i_cfg_addr == 6'(8 + k)) ? 8'd0 :
                       (ev[k] && !mode_q[k] && pend_q[k] && cnt_q[k] != 8'hff) ? cnt_q[k] + 8'd1 : cnt_q[k];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= cnt_d[k];
        end
    end
`endif

    always_comb begin
        rd = '0;
        rd[NUM_SRC-1:0] = (i_cfg_addr == 6'd0) ? en_q :
                          (i_cfg_addr == 6'd1) ? mode_q :
                          (i_cfg_addr == 6'd2) ? pend_q[NUM_SRC-1:0] :
                          (i_cfg_addr == 6'd3) ? s[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
`ifdef IRQ_LOSTCNT_EN
        for (int k = 0; k < NUM_SRC; k++)
            if (i_cfg_addr == 6'(8 + k)) rd = {24'd0, cnt_q[k]};
`endif
        rdata_d  = i_cfg_rden ? rd : '0;
        rvalid_d = i_cfg_rden;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q   <= '0;
            pend_q   <= '0;
            en_q     <= '1;
            mode_q   <= '0;
            irq_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            prev_q   <= s;
            pend_q   <= pend_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_irq_ctrl_multi.sv
// tb_irq_ctrl_multi: directed self-checking bench for irq_ctrl_multi with default parameters.
module tb_irq_ctrl_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq = '0;
    logic        irq_timer = 1'b0;
    logic [31:0] o_irq;
    logic        ack = 1'b0;
    logic [4:0]  id = '0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_ctrl_multi dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_irq_timer(irq_timer), .o_irq(o_irq),
        .i_irq_ack(ack), .i_irq_id(id), .i_cfg_wren(wren), .i_cfg_rden(rden),
        .i_cfg_addr(addr), .i_cfg_wdata(wdata), .o_cfg_rvalid(rvalid), .o_cfg_rdata(rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [5:0] a, input logic [31:0] d);
        wren = 1'b1; addr = a; wdata = d;
        step(1);
        wren = 1'b0;
    endtask

    task automatic cfg_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        rden = 1'b1; addr = a;
        step(1);
        rden = 1'b0;
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check(tag, rdata, exp);
    endtask

    task automatic do_ack(input logic [4:0] i);
        ack = 1'b1; id = i;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        step(3);
        check("rst_irq", o_irq, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        step(1);
        cfg_rd("rst_en", 6'd0, 32'hff);
        cfg_rd("rst_mode", 6'd1, 32'h0);
        cfg_rd("rst_pend", 6'd2, 32'h0);

        // rising edge on src 0 appears exactly SYNC_STAGES+2 = 4 edges later
        irq[0] = 1'b1;
        step(3);
        check("t1_early", o_irq, 32'd0);
        step(1);
        check("t1_fire", o_irq, 32'h0001_0000);
        do_ack(5'd16);
        check("t1_ack", o_irq, 32'd0);
        cfg_rd("t1_pend", 6'd2, 32'h0);
        irq[0] = 1'b0;
        step(3);

        // level mode re-raise
        cfg_wr(6'd1, 32'h08);
        irq[3] = 1'b1;
        step(4);
        check("t2_fire", o_irq, 32'h0008_0000);
        do_ack(5'd19);
        step(1);
        check("t2_reraise", o_irq, 32'h0008_0000);
        irq[3] = 1'b0;
        step(3);
        do_ack(5'd19);
        check("t2_ack", o_irq, 32'd0);
        step(3);
        check("t2_stay", o_irq, 32'd0);
        cfg_wr(6'd1, 32'h0);

        // disabled source still pends, fires on re-enable
        cfg_wr(6'd0, 32'hfe);
        irq[0] = 1'b1;
        step(1);
        irq[0] = 1'b0;
        step(6);
        check("t3_masked", o_irq, 32'd0);
        cfg_rd("t3_pend", 6'd2, 32'h01);
        cfg_wr(6'd0, 32'hff);
        step(1);
        check("t3_reen", o_irq, 32'h0001_0000);
        do_ack(5'd16);
        check("t3_ack", o_irq, 32'd0);

        // same-cycle write and read returns old value
        wren = 1'b1; rden = 1'b1; addr = 6'd0; wdata = 32'h0f;
        step(1);
        wren = 1'b0; rden = 1'b0;
        check("rw_old", rdata, 32'hff);
        cfg_rd("rw_new", 6'd0, 32'h0f);
        cfg_wr(6'd0, 32'hff);

        // edge coincident with ack: set wins
        irq[2] = 1'b1;
        step(4);
        check("t4_fire", o_irq, 32'h0004_0000);
        irq[2] = 1'b0;
        step(3);
        irq[2] = 1'b1;
        step(2);
        do_ack(5'd18);
        check("t4_hold", o_irq, 32'h0004_0000);
        cfg_rd("t4_pend", 6'd2, 32'h04);
        check("t4_hold2", o_irq, 32'h0004_0000);
        do_ack(5'd18);
        check("t4_ack", o_irq, 32'd0);
        irq[2] = 1'b0;
        step(3);

        // write-1-to-clear pending
        cfg_wr(6'd0, 32'hfd);
        irq[1] = 1'b1;
        step(1);
        irq[1] = 1'b0;
        step(4);
        cfg_rd("w1c_set", 6'd2, 32'h02);
        cfg_wr(6'd2, 32'h02);
        cfg_rd("w1c_clr", 6'd2, 32'h00);
        cfg_wr(6'd0, 32'hff);

        // timer and unmapped ack
        irq_timer = 1'b1;
        step(1);
        irq_timer = 1'b0;
        step(3);
        check("t5_fire", o_irq, 32'h0000_0080);
        do_ack(5'd7);
        check("t5_ack", o_irq, 32'd0);
        irq_timer = 1'b1;
        step(1);
        irq_timer = 1'b0;
        step(3);
        do_ack(5'd31);
        check("t5_ack31", o_irq, 32'h0000_0080);
        do_ack(5'd7);
        step(1);

        // raw synchronised inputs and unmapped read
        irq = 8'h05;
        step(3);
        cfg_rd("raw", 6'd3, 32'h05);
        cfg_rd("unmapped", 6'd5, 32'h0);
        irq = 8'h00;
        step(3);
        do_ack(5'd16);
        do_ack(5'd18);
        step(1);
        check("clean", o_irq, 32'd0);

`ifdef IRQ_LOSTCNT_EN
        for (int i = 0; i < 300; i++) begin
            irq[1] = 1'b1;
            step(1);
            irq[1] = 1'b0;
            step(1);
        end
        step(4);
        check("t6_irq", o_irq, 32'h0002_0000);
        cfg_rd("t6_sat", 6'd9, 32'd255);
        cfg_wr(6'd9, 32'd0);
        cfg_rd("t6_clr", 6'd9, 32'd0);
`else
        cfg_rd("t6_nocnt", 6'd9, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
